// File: rtl/env_slot_engine.sv
// env_slot_engine: time-multiplexed ADSR envelope engine, one slot step per clock, 2-clock latency.
// Optional feature macro ENV_EXP_REL_EN selects an exponential release decrement.
module env_slot_engine #(
    parameter int VOICES  = 8,
    parameter int V_ENVS  = 8,
    parameter int V_WIDTH = 3,
    parameter int E_WIDTH = 3
) (
    input  logic                       sCLK_XVXENVS,
    input  logic                       reset_reg,
    input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    input  logic                       xxxx_zero,
    input  logic [VOICES-1:0]          gate,
    input  logic                       prm_wr,
    input  logic [E_WIDTH-1:0]         prm_env,
    input  logic [1:0]                 prm_sel,
    input  logic [15:0]                prm_data,
    output logic [15:0]                env_level,
    output logic [V_WIDTH+E_WIDTH-1:0] env_slot,
    output logic                       env_valid,
    output logic [VOICES-1:0]          voice_busy
);
    localparam int SW    = V_WIDTH + E_WIDTH;
    localparam int SLOTS = VOICES * V_ENVS;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic [2:0]        state_mem_q [SLOTS];
    logic [15:0]       level_mem_q [SLOTS];
    logic [SLOTS-1:0]  gate_mem_q;

    logic [15:0]       prm_a_q [V_ENVS];
    logic [15:0]       prm_d_q [V_ENVS];
    logic [15:0]       prm_s_q [V_ENVS];
    logic [15:0]       prm_r_q [V_ENVS];

    logic              s1_valid_q, s1_valid_d;
    logic [SW-1:0]     s1_slot_q, s1_slot_d;
    logic              s1_gate_q, s1_gate_d;
    logic              s1_zero_q, s1_zero_d;

    logic              env_valid_q, env_valid_d;
    logic [15:0]       env_level_q, env_level_d;
    logic [SW-1:0]     env_slot_q, env_slot_d;
    logic [VOICES-1:0] voice_busy_q, voice_busy_d;
    logic [VOICES-1:0] busy_acc_q, busy_acc_d;

    logic [2:0]        wr_state_d;
    logic [15:0]       wr_level_d;

    logic [2:0]         cur_state;
    logic [15:0]        cur_level;
    logic               prev_gate, rise, fall;
    logic [E_WIDTH-1:0] s1_env;
    logic [V_WIDTH-1:0] s1_voice;
    logic [15:0]        pa, pd, ps, pr;
    logic [16:0]        sum_a, diff_d, rel_dec, diff_r;
    logic               rel_hold;

    // Stage 0: capture the slot index and the gate of its voice.
    always_comb begin
        s1_valid_d = 1'b1;
        s1_slot_d  = xxxx;
        s1_gate_d  = gate[xxxx[SW-1:E_WIDTH]];
        s1_zero_d  = xxxx_zero;
    end

    // Stage 1: the slot state is read combinationally, so a repeated index sees the previous write-back.
    always_comb begin
        s1_env    = s1_slot_q[E_WIDTH-1:0];
        s1_voice  = s1_slot_q[SW-1:E_WIDTH];
        cur_state = state_mem_q[s1_slot_q];
        cur_level = level_mem_q[s1_slot_q];
        prev_gate = gate_mem_q[s1_slot_q];
        rise      = s1_gate_q & ~prev_gate;
        fall      = ~s1_gate_q & prev_gate;
        pa        = prm_a_q[s1_env];
        pd        = prm_d_q[s1_env];
        ps        = prm_s_q[s1_env];
        pr        = prm_r_q[s1_env];
        sum_a     = {1'b0, cur_level} + {1'b0, pa};
        diff_d    = {1'b0, cur_level} - {1'b0, pd};
`ifdef ENV_EXP_REL_EN
        rel_dec   = {1'b0, cur_level >> pr[3:0]} + 17'd1;
        rel_hold  = 1'b0;
`else
        rel_dec   = {1'b0, pr};
        rel_hold  = (pr == '0);
`endif
        diff_r    = {1'b0, cur_level} - rel_dec;

        wr_state_d = cur_state;
        wr_level_d = cur_level;
        if (rise) begin
            wr_state_d = ST_ATTACK;
        end else if (fall && (cur_state == ST_ATTACK || cur_state == ST_DECAY ||
                              cur_state == ST_SUSTAIN)) begin
            wr_state_d = ST_RELEASE;
        end else begin
            case (cur_state)
                ST_ATTACK: begin
                    if (pa != '0) begin
                        if (sum_a[16] || sum_a[15:0] == 16'hFFFF) begin
                            wr_level_d = 16'hFFFF;
                            wr_state_d = ST_DECAY;
                        end else begin
                            wr_level_d = sum_a[15:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (pd != '0) begin
                        if (diff_d[16] || diff_d[15:0] <= ps) begin
                            wr_level_d = ps;
                            wr_state_d = ST_SUSTAIN;
                        end else begin
                            wr_level_d = diff_d[15:0];
                        end
                    end
                end
                ST_SUSTAIN: wr_level_d = ps;
                ST_RELEASE: begin
                    if (!rel_hold) begin
                        if (diff_r[16] || diff_r[15:0] == '0) begin
                            wr_level_d = '0;
                            wr_state_d = ST_IDLE;
                        end else begin
                            wr_level_d = diff_r[15:0];
                        end
                    end
                end
                default: begin
                    wr_state_d = ST_IDLE;
                    wr_level_d = '0;
                end
            endcase
        end
    end

    // Busy flags accumulate the post-step state; the end-of-frame slot folds itself in before the transfer.
    always_comb begin
        env_valid_d  = s1_valid_q;
        env_level_d  = env_level_q;
        env_slot_d   = env_slot_q;
        busy_acc_d   = busy_acc_q;
        voice_busy_d = voice_busy_q;
        if (s1_valid_q) begin
            env_level_d          = wr_level_d;
            env_slot_d           = s1_slot_q;
            busy_acc_d[s1_voice] = busy_acc_q[s1_voice] | (wr_state_d != ST_IDLE);
            if (s1_zero_q) begin
                voice_busy_d = busy_acc_d;
                busy_acc_d   = '0;
            end
        end
    end

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset_reg) begin
            s1_valid_q   <= 1'b0;
            s1_slot_q    <= '0;
            s1_gate_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            env_valid_q  <= 1'b0;
            env_level_q  <= '0;
            env_slot_q   <= '0;
            voice_busy_q <= '0;
            busy_acc_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_slot_q    <= s1_slot_d;
            s1_gate_q    <= s1_gate_d;
            s1_zero_q    <= s1_zero_d;
            env_valid_q  <= env_valid_d;
            env_level_q  <= env_level_d;
            env_slot_q   <= env_slot_d;
            voice_busy_q <= voice_busy_d;
            busy_acc_q   <= busy_acc_d;
        end
    end

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset_reg) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                state_mem_q[i] <= ST_IDLE;
                level_mem_q[i] <= '0;
            end
            gate_mem_q <= '0;
        end else if (s1_valid_q) begin
            state_mem_q[s1_slot_q] <= wr_state_d;
            level_mem_q[s1_slot_q] <= wr_level_d;
            gate_mem_q[s1_slot_q]  <= s1_gate_q;
        end
    end

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset_reg) begin
            for (int unsigned i = 0; i < V_ENVS; i++) begin
                prm_a_q[i] <= 16'h0100;
                prm_d_q[i] <= 16'h0040;
                prm_s_q[i] <= 16'h8000;
                prm_r_q[i] <= 16'h0040;
            end
        end else if (prm_wr) begin
            case (prm_sel)
                2'd0:    prm_a_q[prm_env] <= prm_data;
                2'd1:    prm_d_q[prm_env] <= prm_data;
                2'd2:    prm_s_q[prm_env] <= prm_data;
                default: prm_r_q[prm_env] <= prm_data;
            endcase
        end
    end

    assign env_valid  = env_valid_q;
    assign env_level  = env_level_q;
    assign env_slot   = env_slot_q;
    assign voice_busy = voice_busy_q;

endmodule

// File: tb/tb_env_slot_engine.sv
// Scoreboard bench for env_slot_engine: a frame-level ADSR reference model predicts every output beat.
module tb_env_slot_engine;
    localparam int NV = 8;
    localparam int NE = 8;
    localparam int NS = NV * NE;

    logic        clk = 1'b0;
    logic        reset_reg;
    logic [5:0]  xxxx;
    logic        xxxx_zero;
    logic [7:0]  gate;
    logic        prm_wr;
    logic [2:0]  prm_env;
    logic [1:0]  prm_sel;
    logic [15:0] prm_data;
    logic [15:0] env_level;
    logic [5:0]  env_slot;
    logic        env_valid;
    logic [7:0]  voice_busy;

    always #5 clk = ~clk;

    env_slot_engine #(.VOICES(8), .V_ENVS(8), .V_WIDTH(3), .E_WIDTH(3)) dut (
        .sCLK_XVXENVS(clk),
        .reset_reg   (reset_reg),
        .xxxx        (xxxx),
        .xxxx_zero   (xxxx_zero),
        .gate        (gate),
        .prm_wr      (prm_wr),
        .prm_env     (prm_env),
        .prm_sel     (prm_sel),
        .prm_data    (prm_data),
        .env_level   (env_level),
        .env_slot    (env_slot),
        .env_valid   (env_valid),
        .voice_busy  (voice_busy)
    );

    typedef enum int {M_IDLE, M_ATK, M_DEC, M_SUS, M_REL} mst_t;
    typedef struct {
        int due;
        int slot;
        int lvl;
        int busy;
    } exp_t;

    mst_t m_st   [NS];
    int   m_lvl  [NS];
    bit   m_gate [NS];
    int   m_prm  [NE][4];
    int   m_acc;
    int   m_busy;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    int   next_slot = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_st[i] = M_IDLE;
            m_lvl[i] = 0;
            m_gate[i] = 1'b0;
        end
        for (int e = 0; e < NE; e++) begin
            m_prm[e][0] = 'h0100;
            m_prm[e][1] = 'h0040;
            m_prm[e][2] = 'h8000;
            m_prm[e][3] = 'h0040;
        end
        m_acc = 0;
        m_busy = 0;
    endfunction

    function automatic void model_step(input int slot, input bit g, input bit zero);
        int e = slot % NE;
        int v = slot / NE;
        int a = m_prm[e][0];
        int d = m_prm[e][1];
        int s = m_prm[e][2];
        int r = m_prm[e][3];
        int t;
        int dec;
        bit prev = m_gate[slot];
        m_gate[slot] = g;
        if (g && !prev) begin
            m_st[slot] = M_ATK;
        end else if (!g && prev && (m_st[slot] == M_ATK || m_st[slot] == M_DEC || m_st[slot] == M_SUS)) begin
            m_st[slot] = M_REL;
        end else begin
            case (m_st[slot])
                M_ATK: if (a != 0) begin
                    t = m_lvl[slot] + a;
                    if (t >= 65535) begin
                        t = 65535;
                        m_st[slot] = M_DEC;
                    end
                    m_lvl[slot] = t;
                end
                M_DEC: if (d != 0) begin
                    t = m_lvl[slot] - d;
                    if (t <= s) begin
                        t = s;
                        m_st[slot] = M_SUS;
                    end
                    m_lvl[slot] = t;
                end
                M_SUS: m_lvl[slot] = s;
                M_REL: begin
`ifdef ENV_EXP_REL_EN
                    dec = (m_lvl[slot] >> (r % 16)) + 1;
`else
                    dec = r;
`endif
                    if (dec != 0) begin
                        t = m_lvl[slot] - dec;
                        if (t <= 0) begin
                            t = 0;
                            m_st[slot] = M_IDLE;
                        end
                        m_lvl[slot] = t;
                    end
                end
                default: m_lvl[slot] = 0;
            endcase
        end
        if (m_st[slot] != M_IDLE) m_acc = m_acc | (1 << v);
        if (zero) begin
            m_busy = m_acc;
            m_acc = 0;
        end
    endfunction

    // One clock of stimulus; the expected beat is due two edges after the slot is sampled.
    task automatic tick(input bit rnd, input bit wr, input int env, input int sel, input int data);
        int  slot = next_slot;
        bit  zero = (next_slot == NS - 1);
        exp_t x;
        if (rnd && $urandom_range(0, 31) == 0) slot = $urandom_range(0, NS - 1);
        if (!(rnd && $urandom_range(0, 31) == 0)) next_slot = (next_slot + 1) % NS;
        xxxx = 6'(slot);
        xxxx_zero = zero;
        prm_wr = wr;
        prm_env = 3'(env);
        prm_sel = 2'(sel);
        prm_data = 16'(data);
        if (wr) m_prm[env][sel] = data;
        model_step(slot, gate[slot / NE], zero);
        x.due = cyc + 2;
        x.slot = slot;
        x.lvl = m_lvl[slot];
        x.busy = m_busy;
        sbq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frames(input int n, input bit rnd);
        int sel;
        int data;
        repeat (n * NS) begin
            if (rnd && $urandom_range(0, 127) == 0) gate[$urandom_range(0, NV - 1)] ^= 1'b1;
            if (rnd && $urandom_range(0, 15) == 0) begin
                sel = $urandom_range(0, 3);
                case ($urandom_range(0, 3))
                    0: data = 0;
                    1: data = $urandom_range(1, 'h1000);
                    2: data = $urandom_range(0, 'hFFFF);
                    default: data = 'hFFF0 + $urandom_range(0, 15);
                endcase
                tick(rnd, 1'b1, $urandom_range(0, NE - 1), sel, data);
            end else begin
                tick(rnd, 1'b0, 0, 0, 0);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    // Beats in flight that the reset edge will squash are dropped from the scoreboard.
    task automatic do_reset(input int n);
        reset_reg = 1'b1;
        prm_wr = 1'b0;
        while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_env_valid", int'(env_valid), 0);
        chk("reset_env_level", int'(env_level), 0);
        chk("reset_env_slot", int'(env_slot), 0);
        chk("reset_voice_busy", int'(voice_busy), 0);
        repeat (n - 1) @(posedge clk);
        if (n > 1) #1;
        reset_reg = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                mon_e = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL late_beat slot=%0d: no output at cycle %0d", mon_e.slot, mon_e.due);
            end
            if (env_valid) begin
                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    mon_e = sbq.pop_front();
                    total++;
                    if (int'(env_slot) != mon_e.slot || int'(env_level) != mon_e.lvl ||
                        int'(voice_busy) != mon_e.busy) begin
                        bad++;
                        $display("FAIL beat cyc=%0d: slot got %0d want %0d, level got 0x%04h want 0x%04h, busy got 0x%02h want 0x%02h",
                                 cyc, env_slot, mon_e.slot, env_level, mon_e.lvl, voice_busy, mon_e.busy);
                    end
                end else begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid cyc=%0d: slot got %0d level got 0x%04h, none required", cyc, env_slot, env_level);
                end
            end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
                mon_e = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL missing_valid cyc=%0d: env_valid got 0 want 1 (slot %0d)", cyc, mon_e.slot);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reg = 1'b1;
        xxxx = '0;
        xxxx_zero = 1'b0;
        gate = '0;
        prm_wr = 1'b0;
        prm_env = '0;
        prm_sel = '0;
        prm_data = '0;
        do_reset(3);
        next_slot = 0;
        mon_en = 1'b1;

        run_frames(3, 1'b0);

        gate = 8'h01;
        run_frames(300, 1'b0);

        for (int e = 0; e < NE; e++) tick(1'b0, 1'b1, e, 1, 'h0400);
        run_frames(40, 1'b0);
        tick(1'b0, 1'b1, 0, 2, 'h4000);
        run_frames(2, 1'b0);

        tick(1'b0, 1'b1, 0, 3, 'h1000);
        gate = 8'h00;
        run_frames(2, 1'b0);
        gate = 8'h01;
        run_frames(3, 1'b0);
        gate = 8'h00;
        run_frames(6, 1'b0);

        run_frames(300, 1'b1);

        for (int e = 0; e < NE; e++) tick(1'b0, 1'b1, e, 0, 'h2000);
        gate = 8'hFF;
        run_frames(4, 1'b0);
        while (next_slot != 37) tick(1'b0, 1'b0, 0, 0, 0);
        xxxx = 6'd37;
        do_reset(2);

        gate = 8'h00;
        run_frames(3, 1'b0);
        gate = 8'h5A;
        run_frames(20, 1'b1);

        @(negedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
